// File: rtl/obstacle_collision_checker_if.sv
// Obstacle-movement to collision-checker signal bundle.
// The checker consumes positions and frame/restart pulses, and drives
// hit, lives and status back to the game logic.
interface obstacle_collision_checker_if #(
    parameter int NB_LANES = 4
);
    logic                      i_Frame_Start;
    logic [10*NB_LANES-1:0]    i_Car_X_Bus;
    logic [9:0]                i_Frog_X;
    logic [3:0]                i_Frog_Row;
    logic                      i_Restart;
    logic                      o_Hit;
    logic [2:0]                o_Hit_Lane;
    logic [2:0]                o_Lives;
    logic                      o_Game_Over;
    logic                      o_Busy;

    modport master (
        output i_Frame_Start, i_Car_X_Bus, i_Frog_X, i_Frog_Row, i_Restart,
        input  o_Hit, o_Hit_Lane, o_Lives, o_Game_Over, o_Busy
    );

    modport slave (
        input  i_Frame_Start, i_Car_X_Bus, i_Frog_X, i_Frog_Row, i_Restart,
        output o_Hit, o_Hit_Lane, o_Lives, o_Game_Over, o_Busy
    );
endinterface

// File: rtl/obstacle_collision_checker.sv
// Frog/car collision checker: snapshots positions once per frame, scans
// one lane per clock, and manages lives, grace period and game over.
module obstacle_collision_checker #(
    parameter int NB_LANES      = 4,
    parameter int LANE_ROW_BASE = 5,
    parameter int TILE_SIZE     = 32,
    parameter int CAR_WIDTH     = 32,
    parameter int START_LIVES   = 3,
    parameter int GRACE_FRAMES  = 60
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    obstacle_collision_checker_if.slave   bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SNAPSHOT = 3'd1;
    localparam logic [2:0] ST_SCAN     = 3'd2;
    localparam logic [2:0] ST_HIT      = 3'd3;
    localparam logic [2:0] ST_GRACE    = 3'd4;
    localparam logic [2:0] ST_OVER     = 3'd5;

    logic [2:0]               state;
    logic [2:0]               lane_idx;
    logic [10*NB_LANES-1:0]   snap_car;
    logic [9:0]               snap_frog_x;
    logic [3:0]               snap_frog_row;
    logic [7:0]               grace_cnt;
    logic [2:0]               hit_lane;
    logic [2:0]               lives;

    logic [9:0]               car_x;
    logic [10:0]              car_end;
    logic [10:0]              frog_end;
    logic                     row_match;
    logic                     overlap;

    // Select the current lane's car and test row match plus 11-bit interval overlap
    always_comb begin
        car_x = '0;
        for (int unsigned k = 0; k < NB_LANES; k++) begin
            if (lane_idx == 3'(k)) begin
                car_x = snap_car[10*k +: 10];
            end
        end
        car_end   = {1'b0, car_x} + 11'(CAR_WIDTH);
        frog_end  = {1'b0, snap_frog_x} + 11'(TILE_SIZE);
        row_match = ({1'b0, snap_frog_row} == (5'(LANE_ROW_BASE) + {2'b00, lane_idx}));
        overlap   = row_match
                    && ({1'b0, snap_frog_x} < car_end)
                    && ({1'b0, car_x} < frog_end);
    end

    // Frame-driven scan FSM with lives, grace countdown and restart handling
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= ST_IDLE;
            lane_idx      <= '0;
            snap_car      <= '0;
            snap_frog_x   <= '0;
            snap_frog_row <= '0;
            grace_cnt     <= '0;
            hit_lane      <= '0;
            lives         <= 3'(START_LIVES);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_Frame_Start) begin
                        state <= ST_SNAPSHOT;
                    end
                end
                ST_SNAPSHOT: begin
                    snap_car      <= bus.i_Car_X_Bus;
                    snap_frog_x   <= bus.i_Frog_X;
                    snap_frog_row <= bus.i_Frog_Row;
                    lane_idx      <= '0;
                    state         <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (overlap) begin
                        hit_lane <= lane_idx;
                        state    <= ST_HIT;
                    end else if (lane_idx == 3'(NB_LANES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        lane_idx <= lane_idx + 3'd1;
                    end
                end
                ST_HIT: begin
                    if (lives <= 3'd1) begin
                        lives <= '0;
                        state <= ST_OVER;
                    end else begin
                        lives     <= lives - 3'd1;
                        grace_cnt <= 8'(GRACE_FRAMES);
                        state     <= ST_GRACE;
                    end
                end
                ST_GRACE: begin
                    if (bus.i_Frame_Start) begin
                        if (grace_cnt <= 8'd1) begin
                            grace_cnt <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            grace_cnt <= grace_cnt - 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.i_Restart) begin
                        lives <= 3'(START_LIVES);
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Hit       = (state == ST_HIT);
    assign bus.o_Hit_Lane  = hit_lane;
    assign bus.o_Lives     = lives;
    assign bus.o_Game_Over = (state == ST_OVER);
    assign bus.o_Busy      = (state == ST_SNAPSHOT) || (state == ST_SCAN) || (state == ST_HIT);

endmodule

// File: doc/obstacle_collision_checker.md
Name: obstacle_collision_checker

Overview:
- Consumer side of the obstacle-movement interface. Takes the per-lane car X positions from the movement blocks and the frog's position.
- Once per video frame it snapshots all positions and scans the lanes one per clock for frog/car overlap.
- On a collision it pulses a hit, decrements lives and enters a grace period, or declares game over.
- Sits between the obstacle movement blocks, the frog controller, and the game-state/score logic.

Parameters:
- NB_LANES, 4, number of car lanes checked (1..8).
- LANE_ROW_BASE, 5, tile row of lane 0; lane k occupies tile row LANE_ROW_BASE+k.
- TILE_SIZE, 32, frog width in pixels.
- CAR_WIDTH, 32, car width in pixels.
- START_LIVES, 3, lives loaded at reset and restart (1..7).
- GRACE_FRAMES, 60, frames of collision immunity after a hit (1..255).

Ports:
- i_Clk, input, 1, system clock (25 MHz pixel clock).
- i_Reset, input, 1, asynchronous active-high reset.
- i_Frame_Start, input, 1, one-cycle pulse at start of each frame.
- i_Car_X_Bus, input, 10*NB_LANES, packed car X positions; lane k in bits [10k+9:10k].
- i_Frog_X, input, 10, frog left-edge pixel X.
- i_Frog_Row, input, 4, frog tile row (0..14).
- i_Restart, input, 1, one-cycle pulse; honoured only in OVER.
- o_Hit, output, 1, one-cycle collision pulse.
- o_Hit_Lane, output, 3, lane index of last collision; holds until next hit.
- o_Lives, output, 3, remaining lives.
- o_Game_Over, output, 1, high while in OVER.
- o_Busy, output, 1, high in SNAPSHOT, SCAN and HIT.

Behaviour:
- Clock and reset: single clock i_Clk. i_Reset is asynchronous and active-high.
- Reset values: state IDLE; o_Hit=0; o_Hit_Lane=0; o_Lives=START_LIVES; o_Game_Over=0; o_Busy=0; grace counter=0; lane index=0. Asserting reset mid-scan aborts the scan and no o_Hit is produced.
- FSM states: IDLE, SNAPSHOT, SCAN, HIT, GRACE, OVER.
- IDLE: on i_Frame_Start go to SNAPSHOT.
- SNAPSHOT (1 cycle): register i_Car_X_Bus, i_Frog_X and i_Frog_Row; clear lane index; go to SCAN. Input changes after this cycle do not affect the current frame.
- SCAN: evaluates lane idx each cycle. Overlap requires both:
  - row match: snapped frog row == LANE_ROW_BASE+idx;
  - interval overlap: frog_x < car_x+CAR_WIDTH AND car_x < frog_x+TILE_SIZE, computed at 11 bits with no truncation.
- SCAN transitions:
  - first overlap found: latch idx into o_Hit_Lane, go to HIT (lower lanes win);
  - else if idx==NB_LANES-1: go to IDLE;
  - else idx+1.
- HIT (1 cycle): o_Hit=1 and o_Lives decrements.
  - If the new value is 0: go to OVER.
  - Otherwise: load grace counter with GRACE_FRAMES and go to GRACE.
- Hit latency: a lane-k hit gives o_Hit in cycle k+3 after the i_Frame_Start cycle. Worst case is NB_LANES+2.
- GRACE: no checking. Each i_Frame_Start decrements the counter. When the counter reaches 0 the state returns to IDLE; checking resumes on the next i_Frame_Start, not the one that ended grace.
- OVER: o_Game_Over=1 and frames are ignored. On i_Restart: o_Lives=START_LIVES, o_Game_Over=0, go to IDLE. The first check then happens on the next i_Frame_Start.
- i_Frame_Start during SNAPSHOT/SCAN/HIT is ignored.
- i_Restart outside OVER is ignored.
- o_Lives never underflows and never exceeds START_LIVES.
- A frog row outside the lane rows never collides.
- Car X at 0 or 608 (wrap endpoints) is treated as an ordinary position.

Test Plan:
1. Reset, frog row 5 X=100, lane0 car X=120, pulse frame at cycle T → o_Hit=1 at T+3, o_Hit_Lane=0, o_Lives 3→2, state GRACE.
2. Frog X=100, lane0 car X=132 (edge-adjacent) and car X=68 → no hit; car X=131 and X=69 → hit on each (separate runs).
3. Frog row 7, cars overlapping in lanes 2 and 3 → single o_Hit, o_Hit_Lane=2, lives decremented once.
4. After a hit with GRACE_FRAMES=3, keep overlap → no o_Hit for 3 frames; hit on the 4th frame pulse after grace ends.
5. Three hits from START_LIVES=3 → o_Lives=0, o_Game_Over=1, later frames give no o_Hit; i_Restart → o_Lives=3, o_Game_Over=0.
6. Assert i_Reset during SCAN with a pending overlap → no o_Hit, outputs at reset values; i_Frame_Start during o_Busy ignored (one scan only).
